// File: rtl/calc_n_core_if.sv
// rtl/calc_n_core_if.sv - request/response bundle for the multi-port calculator
interface calc_n_core_if #(
  parameter int PORTS = 4,
  parameter int WIDTH = 32
);
  logic [4*PORTS-1:0]     req_cmd_in;
  logic [WIDTH*PORTS-1:0] req_data_in;
  logic [PORTS-1:0]       req_ready;
  logic [2*PORTS-1:0]     out_resp;
  logic [WIDTH*PORTS-1:0] out_data;

  modport master (
    output req_cmd_in, req_data_in,
    input  req_ready, out_resp, out_data
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output req_ready, out_resp, out_data
  );
endinterface

// File: rtl/calc_n_core.sv
// rtl/calc_n_core.sv - PORTS-port calculator: per-port capture FSM and FIFO, round-robin arbiter, shared registered ALU
module calc_n_core #(
  parameter int PORTS = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic          c_clk,
  input  logic          reset,
  calc_n_core_if.slave  bus
);

  localparam int QW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int SHW = $clog2(WIDTH);
  localparam int EW  = 4 + 2 * WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } cap_state_e;

  logic [PORTS-1:0]         ready;
  logic [PORTS-1:0]         nonempty;
  logic [PORTS-1:0]         grant_oh;
  logic [PORTS-1:0][EW-1:0] head;

  logic                     grant_vld;
  logic [PW-1:0]            grant_idx;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;

  logic [EW-1:0]            sel_entry;
  logic [3:0]               alu_cmd;
  logic [WIDTH-1:0]         alu_a, alu_b;
  logic [WIDTH:0]           alu_sum;
  logic [SHW-1:0]           alu_shamt;
  logic [1:0]               alu_resp;
  logic [WIDTH-1:0]         alu_data;

  logic [2*PORTS-1:0]       out_resp_q, out_resp_d;
  logic [WIDTH*PORTS-1:0]   out_data_q, out_data_d;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] ptr);
    return (ptr == QW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  for (genvar g = 0; g < PORTS; g++) begin : g_port
    cap_state_e       state_q, state_d;
    logic [3:0]       cmd_q;
    logic [WIDTH-1:0] op1_q;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [QW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [3:0]       cmd_in;
    logic [WIDTH-1:0] data_in;
    logic             rdy;
    logic             push;

    assign cmd_in      = bus.req_cmd_in[4*g +: 4];
    assign data_in     = bus.req_data_in[WIDTH*g +: WIDTH];
    // Ready only in IDLE with room, so a captured request always has a slot at its push edge.
    assign rdy         = (state_q == ST_IDLE) && (count_q < CW'(DEPTH));
    assign ready[g]    = rdy;
    assign nonempty[g] = (count_q != '0);
    assign head[g]     = mem_q[rd_ptr_q];

    always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rdy && (cmd_in != 4'd0)) begin
            state_d = ST_OP2;
          end
        end
        ST_OP2: begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        state_q  <= ST_IDLE;
        cmd_q    <= '0;
        op1_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        state_q <= state_d;
        if ((state_q == ST_IDLE) && (state_d == ST_OP2)) begin
          cmd_q <= cmd_in;
          op1_q <= data_in;
        end
        if (push) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
        if (grant_oh[g]) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
        if (push && !grant_oh[g]) begin
          count_q <= count_q + 1'b1;
        end else if (!push && grant_oh[g]) begin
          count_q <= count_q - 1'b1;
        end
      end
    end

    always_ff @(posedge c_clk) begin
      if (push) begin
        mem_q[wr_ptr_q] <= {cmd_q, op1_q, data_in};
      end
    end
  end

  // Round-robin: first non-empty queue at or after the pointer wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int i = 0; i < PORTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= PORTS) begin
        idx = idx - PORTS;
      end
      if (!grant_vld && nonempty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    sel_entry = head[grant_idx];
    alu_cmd   = sel_entry[EW-1 -: 4];
    alu_a     = sel_entry[2*WIDTH-1 -: WIDTH];
    alu_b     = sel_entry[WIDTH-1:0];
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_shamt = alu_b[SHW-1:0];
    alu_resp  = 2'd2;
    alu_data  = '0;
    case (alu_cmd)
      4'd1: begin
        if (!alu_sum[WIDTH]) begin
          alu_resp = 2'd1;
          alu_data = alu_sum[WIDTH-1:0];
        end
      end
      4'd2: begin
        if (alu_b <= alu_a) begin
          alu_resp = 2'd1;
          alu_data = alu_a - alu_b;
        end
      end
      4'd5: begin
        alu_resp = 2'd1;
        alu_data = alu_a << alu_shamt;
      end
      4'd6: begin
        alu_resp = 2'd1;
        alu_data = alu_a >> alu_shamt;
      end
      default: begin
        alu_resp = 2'd2;
        alu_data = '0;
      end
    endcase
  end

  // Every port is cleared each cycle so a response lasts exactly one cycle.
  always_comb begin
    out_resp_d = '0;
    out_data_d = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_oh[p]) begin
        out_resp_d[2*p +: 2]         = alu_resp;
        out_data_d[WIDTH*p +: WIDTH] = alu_data;
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      out_resp_q <= '0;
      out_data_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_resp  = out_resp_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: doc/calc_n_core.md
Name: calc_n_core

Overview:
- Parametrised successor to the 4-port calc1 design: PORTS request ports, WIDTH-bit data, DEPTH-entry per-port request queues, one shared registered ALU.
- Each port accepts a two-cycle request (cmd + operand1, then operand2) and queues it; a round-robin arbiter issues one request per cycle to the ALU.
- The 2-bit response and result are returned on the originating port.
- Command and response encodings are unchanged from calc1, so existing drivers and checkers carry over.

Parameters:
PORTS, 4, number of request/response ports (1..8)
WIDTH, 32, operand/result width in bits (>=8, power of two)
DEPTH, 2, per-port request queue entries (>=1)

Ports:
c_clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
req_cmd_in  input  4*PORTS  per-port command; port p at bits [4p+3:4p]
req_data_in  input  WIDTH*PORTS  per-port operand; operand1 in cmd cycle, operand2 in following cycle
req_ready  output  PORTS  port p may present a new command this cycle
out_resp  output  2*PORTS  per-port response: 0 none, 1 success, 2 invalid/overflow, 3 unused
out_data  output  WIDTH*PORTS  per-port result, valid only while matching out_resp != 0

Behaviour:
- Reset (reset=0, async):
  - all port FSMs go to IDLE; queues empty; arbiter pointer = 0.
  - out_resp = 0, out_data = 0, req_ready = all ones (after release).
  - Any in-flight or queued request is discarded; no response is ever produced for it.
- Per-port capture FSM, states IDLE and OP2:
  - IDLE: req_ready[p] = 1 iff queue count < DEPTH.
  - IDLE with cmd != 0 and ready = 1: latch cmd and operand1, go to OP2.
  - IDLE with cmd != 0 and ready = 0: command dropped, no response. The bench must hold cmd=0 while ready=0.
  - OP2: latch operand2, push {cmd, op1, op2} into the queue at this edge, return to IDLE. req_cmd_in is ignored in OP2. req_ready[p] = 0 in OP2.
  - Back-to-back: a new command may be presented in the cycle after OP2 if ready.
- Queue: DEPTH-entry FIFO per port.
  - Push and pop in the same cycle leave count unchanged.
  - Pop happens only on grant.
  - Read/write pointers wrap modulo DEPTH.
- Arbiter: round-robin over non-empty queues, one grant per cycle.
  - Search starts at the pointer; after a grant, pointer = granted port + 1 (mod PORTS).
  - No grant leaves the pointer unchanged.
- ALU, registered:
  - Granted head is computed combinationally; result is registered onto out_resp/out_data of the granted port at the next edge.
  - Response lasts exactly one cycle; all other ports show resp 0, data 0 that cycle.
- Latency: cmd in cycle 0, operand2 in cycle 1, response visible in cycle 3 when uncontended. Each contending request ahead adds one cycle.
- Arithmetic (unsigned WIDTH bits):
  - ADD (1): carry-out gives resp 2, data 0; else resp 1, data op1+op2.
  - SUB (2): op2 > op1 gives resp 2, data 0; else resp 1, data op1-op2.
  - LSH (5) / RSH (6): shift by op2[log2(WIDTH)-1:0]; upper bits of op2 ignored; resp 1; vacated bits zero.
  - Any other nonzero cmd (3, 4, 7..15): resp 2, data 0.
- Ordering: responses per port are in request order; no ordering guarantee across ports.

Test Plan:
- Single ADD on port 0: cmd=1, op1=255, op2=1 -> cycle 3: out_resp[0]=1, out_data[0]=256, other ports resp 0.
- Overflow/underflow: ADD 0xFFFFFFFF+1 -> resp 2, data 0. SUB 3-5 -> resp 2, data 0. SUB 5-5 -> resp 1, data 0.
- Shifts: LSH 0x1 by 35 (WIDTH=32 uses 3) -> resp 1, data 0x8. RSH 0x80000000 by 31 -> data 0x1. cmd=4 -> resp 2.
- Contention: all 4 ports issue ADD p+p in the same cycles -> responses in cycles 3, 4, 5, 6 for ports 0, 1, 2, 3. A second round in the next free cycle continues from port 0 (pointer wrapped).
- Queue full: port 1 sends 3 back-to-back requests while ports 0, 2, 3 saturate the arbiter -> req_ready[1] drops once count = DEPTH = 2. A cmd asserted while ready=0 produces no response. The queued 2 complete in order.
- Reset mid-operation: assert reset during port 2 OP2 with 2 entries queued -> outputs 0 immediately. After release, no stale responses appear and ready is all ones.
